status_indicator_bank: RTL and testbench

Parametrised status-to-LED indicator engine for the CPLD: collects NUM_CHANNELS per-subsystem status signals (spi, data path, storage, rs232, adc, regulator, sensor, thermal) and drives an active-low LED bank. Each channel has a programmable display mode (direct, sticky, stretch, blink), and channels are paged so that more channels than LEDs can be shown. It sits between the subsystem instances and the board LED pins, on the internal-oscillator clock.

---
 rtl/status_indicator_bank_pkg.sv | 21 ++
 rtl/status_indicator_bank_if.sv | 31 +++
 rtl/status_indicator_bank_prescaler.sv | 23 ++
 rtl/status_indicator_bank.sv | 138 +++++++++++++
 tb/tb_status_indicator_bank.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/status_indicator_bank_pkg.sv
// status_indicator_pkg: display modes and width helpers shared by the indicator bank, its interface and bench
package status_indicator_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT  = 2'd0,
        MODE_STICKY  = 2'd1,
        MODE_STRETCH = 2'd2,
        MODE_BLINK   = 2'd3
    } mode_e;

    localparam int TICK_CNT_W = 8;

    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int pages_of(input int channels, input int leds);
        return (channels + leds - 1) / leds;
    endfunction

endpackage

// File: rtl/status_indicator_bank_if.sv
// status_indicator_bank_if: status inputs, mode configuration, paging control and LED outputs of the bank
interface status_indicator_bank_if #(
    parameter int NUM_CHANNELS = 12,
    parameter int NUM_LEDS     = 8
);
    import status_indicator_pkg::*;

    localparam int ADDR_W = width_of(NUM_CHANNELS);
    localparam int PAGE_W = width_of(pages_of(NUM_CHANNELS, NUM_LEDS));

    logic [NUM_CHANNELS-1:0] signal_in;
    logic                    cfg_wr;
    logic [ADDR_W-1:0]       cfg_addr;
    mode_e                   cfg_mode;
    logic                    clear_sticky;
    logic                    page_next;
    logic [NUM_LEDS-1:0]     led_n;
    logic [PAGE_W-1:0]       page;
    logic                    tick;

    modport master (
        output signal_in, cfg_wr, cfg_addr, cfg_mode, clear_sticky, page_next,
        input  led_n, page, tick
    );

    modport slave (
        input  signal_in, cfg_wr, cfg_addr, cfg_mode, clear_sticky, page_next,
        output led_n, page, tick
    );

endinterface

// File: rtl/status_indicator_bank_prescaler.sv
// tick_prescaler: divides the clock down to a one-cycle tick every CLK_HZ/TICK_HZ cycles
module tick_prescaler #(
    parameter int CLK_HZ  = 2080000,
    parameter int TICK_HZ = 16
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int CW  = $clog2(DIV);

    logic [CW-1:0] count;

    assign tick = (count == CW'(DIV - 1));

    // free-running count 0..DIV-1, wrapping in the tick cycle
    always_ff @(posedge clock) begin
        if (!reset) count <= '0;
        else        count <= tick ? '0 : count + 1'b1;
    end

endmodule

// File: rtl/status_indicator_bank.sv
// status_indicator_bank: per-channel status display modes mapped onto a paged active-low LED bank; STATUS_AUTO_PAGE_EN enables timed auto-paging
module status_indicator_bank
    import status_indicator_pkg::*;
#(
    parameter int NUM_CHANNELS  = 12,
    parameter int NUM_LEDS      = 8,
    parameter int CLK_HZ        = 2080000,
    parameter int TICK_HZ       = 16,
    parameter int STRETCH_TICKS = 4,
    parameter int BLINK_TICKS   = 2
`ifdef STATUS_AUTO_PAGE_EN
    ,
    parameter int PAGE_TICKS    = 32
`endif
) (
    input logic                  clock,
    input logic                  reset,
    status_indicator_bank_if.slave bus
);
    localparam int NUM_PAGES = pages_of(NUM_CHANNELS, NUM_LEDS);
    localparam int PAGE_W    = width_of(NUM_PAGES);
    localparam int ADDR_W    = width_of(NUM_CHANNELS);
    localparam int SLOTS     = NUM_PAGES * NUM_LEDS;

    logic                     tick;
    logic                     phase;
    logic [TICK_CNT_W-1:0]    blink_count;
    logic [NUM_CHANNELS-1:0]  signal_q;
    logic [NUM_CHANNELS-1:0]  lit;
    logic [SLOTS-1:0]         slot;
    logic [NUM_LEDS-1:0]      page_bits [NUM_PAGES];
    logic [PAGE_W-1:0]        page;
    logic [NUM_LEDS-1:0]      led_n;
    logic                     advance;

    tick_prescaler #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_prescaler (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    // global blink phase, toggled every BLINK_TICKS ticks
    always_ff @(posedge clock) begin
        if (!reset) begin
            blink_count <= '0;
            phase       <= 1'b0;
        end else if (tick) begin
            blink_count <= (blink_count == TICK_CNT_W'(BLINK_TICKS - 1)) ? '0 : blink_count + 1'b1;
            phase       <= (blink_count == TICK_CNT_W'(BLINK_TICKS - 1)) ? ~phase : phase;
        end
    end

    // registered copy of the inputs for rising-edge detection
    always_ff @(posedge clock) begin
        if (!reset) signal_q <= '0;
        else        signal_q <= bus.signal_in;
    end

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        mode_e                 mode;
        logic                  latch;
        logic [TICK_CNT_W-1:0] count;
        logic                  hit;
        logic                  rise;

        assign hit  = bus.cfg_wr && (bus.cfg_addr == ADDR_W'(c));
        assign rise = bus.signal_in[c] & ~signal_q[c];

        // mode, sticky latch and stretch counter; a config write wipes the channel and drops that cycle's set
        always_ff @(posedge clock) begin
            if (!reset) begin
                mode  <= MODE_DIRECT;
                latch <= 1'b0;
                count <= '0;
            end else if (hit) begin
                mode  <= bus.cfg_mode;
                latch <= 1'b0;
                count <= '0;
            end else begin
                if (mode == MODE_STICKY && bus.signal_in[c]) latch <= 1'b1;
                else if (bus.clear_sticky)                   latch <= 1'b0;
                if (mode == MODE_STRETCH && rise)    count <= TICK_CNT_W'(STRETCH_TICKS);
                else if (tick && count != '0)        count <= count - 1'b1;
            end
        end

        // sticky ORs in the live input so a set shows with the same one-cycle latency as direct
        assign lit[c] = (mode == MODE_DIRECT)  ? bus.signal_in[c] :
                        (mode == MODE_STICKY)  ? bus.signal_in[c] | latch :
                        (mode == MODE_STRETCH) ? bus.signal_in[c] | (count != '0) :
                                                 bus.signal_in[c] & phase;
    end

    assign slot = SLOTS'(lit);

    for (genvar p = 0; p < NUM_PAGES; p++) begin : g_page
        assign page_bits[p] = slot[p*NUM_LEDS +: NUM_LEDS];
    end

`ifdef STATUS_AUTO_PAGE_EN
    localparam int PT_W = $clog2(PAGE_TICKS + 1);

    logic [PT_W-1:0] page_count;
    logic            page_due;

    assign page_due = tick && (page_count == PT_W'(PAGE_TICKS - 1));
    assign advance  = bus.page_next || page_due;

    // ticks spent on the current page; a manual advance restarts the interval
    always_ff @(posedge clock) begin
        if (!reset)        page_count <= '0;
        else if (advance)  page_count <= '0;
        else if (tick)     page_count <= page_count + 1'b1;
    end
`else
    assign advance = bus.page_next;
`endif

    // displayed page, wrapping after the last one
    always_ff @(posedge clock) begin
        if (!reset)       page <= '0;
        else if (advance) page <= (page == PAGE_W'(NUM_PAGES - 1)) ? '0 : page + 1'b1;
    end

    // active-low LED register for the current page
    always_ff @(posedge clock) begin
        if (!reset) led_n <= '1;
        else        led_n <= ~page_bits[page];
    end

    assign bus.led_n = led_n;
    assign bus.page  = page;
    assign bus.tick  = tick;

endmodule

// File: tb/tb_status_indicator_bank.sv
// tb_status_indicator_bank: directed checks of reset, display modes, paging and mid-run reset
module tb_status_indicator_bank;
    import status_indicator_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   t = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    status_indicator_bank_if #(.NUM_CHANNELS(12), .NUM_LEDS(8)) bus ();

    status_indicator_bank #(
        .NUM_CHANNELS  (12),
        .NUM_LEDS      (8),
        .CLK_HZ        (160),
        .TICK_HZ       (16),
        .STRETCH_TICKS (4),
        .BLINK_TICKS   (2)
`ifdef STATUS_AUTO_PAGE_EN
        ,
        .PAGE_TICKS    (2)
`endif
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic step_to(input int target);
        while (t < target) begin
            @(negedge clock);
            t++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.signal_in    = '1;
        bus.cfg_wr       = 1'b0;
        bus.cfg_addr     = '0;
        bus.cfg_mode     = MODE_DIRECT;
        bus.clear_sticky = 1'b0;
        bus.page_next    = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_led", 32'(bus.led_n), 32'hFF);
        check("reset_page", 32'(bus.page), 32'h0);
        check("reset_tick", 32'(bus.tick), 32'h0);
        reset = 1'b1;
        t = 0;
        step_to(1);
        check("direct_all_on", 32'(bus.led_n), 32'h00);
        bus.signal_in = '0;
        step_to(2);
        check("direct_off", 32'(bus.led_n), 32'hFF);
        bus.cfg_wr = 1'b1; bus.cfg_addr = 4'd3; bus.cfg_mode = MODE_STICKY;
        step_to(3);
        bus.cfg_wr = 1'b0;
        bus.signal_in[3] = 1'b1;
        step_to(4);
        check("sticky_set", 32'(bus.led_n), 32'hF7);
        bus.signal_in = '0;
        step_to(8);
        check("sticky_hold", 32'(bus.led_n), 32'hF7);
        bus.clear_sticky = 1'b1;
        step_to(9);
        bus.clear_sticky = 1'b0;
        check("sticky_clear_latency", 32'(bus.led_n), 32'hF7);
        check("tick_high", 32'(bus.tick), 32'h1);
        step_to(10);
        check("sticky_cleared", 32'(bus.led_n), 32'hFF);
        check("tick_low", 32'(bus.tick), 32'h0);
        bus.signal_in[3] = 1'b1; bus.clear_sticky = 1'b1;
        step_to(11);
        bus.signal_in = '0; bus.clear_sticky = 1'b0;
        step_to(12);
        check("sticky_set_wins", 32'(bus.led_n), 32'hF7);
        bus.clear_sticky = 1'b1;
        step_to(13);
        bus.clear_sticky = 1'b0;
        step_to(14);
        check("sticky_reclear", 32'(bus.led_n), 32'hFF);
        bus.cfg_wr = 1'b1; bus.cfg_addr = 4'd5; bus.cfg_mode = MODE_STRETCH;
        step_to(15);
        bus.cfg_wr = 1'b0;
        bus.signal_in[5] = 1'b1;
        step_to(16);
        bus.signal_in = '0;
        check("stretch_start", 32'(bus.led_n), 32'hDF);
        step_to(30);
        check("stretch_mid", 32'(bus.led_n), 32'hDF);
        step_to(50);
        check("stretch_last", 32'(bus.led_n), 32'hDF);
        step_to(51);
        check("stretch_end", 32'(bus.led_n), 32'hFF);
        bus.signal_in[5] = 1'b1;
        step_to(52);
        bus.signal_in = '0;
        step_to(59);
        check("tick_before_reload", 32'(bus.tick), 32'h1);
        bus.signal_in[5] = 1'b1;
        step_to(60);
        bus.signal_in = '0;
        step_to(95);
        check("stretch_reload_mid", 32'(bus.led_n), 32'hDF);
        step_to(100);
        check("stretch_reload_last", 32'(bus.led_n), 32'hDF);
        step_to(101);
        check("stretch_reload_end", 32'(bus.led_n), 32'hFF);
        bus.cfg_wr = 1'b1; bus.cfg_addr = 4'd1; bus.cfg_mode = MODE_BLINK;
        step_to(102);
        bus.cfg_wr = 1'b0;
        bus.signal_in[1] = 1'b1;
        step_to(110);
        check("blink_on", 32'(bus.led_n), 32'hFD);
        step_to(120);
        check("blink_on_last", 32'(bus.led_n), 32'hFD);
        step_to(121);
        check("blink_off", 32'(bus.led_n), 32'hFF);
        step_to(140);
        check("blink_off_last", 32'(bus.led_n), 32'hFF);
        step_to(141);
        check("blink_on_again", 32'(bus.led_n), 32'hFD);
        bus.signal_in = 12'hA01; bus.page_next = 1'b1;
        step_to(142);
        bus.page_next = 1'b0;
        check("page_one", 32'(bus.page), 32'h1);
        check("page0_view", 32'(bus.led_n), 32'hFE);
        step_to(143);
        check("page1_view", 32'(bus.led_n), 32'hF5);
        bus.page_next = 1'b1;
        step_to(144);
        bus.page_next = 1'b0;
        check("page_wrap", 32'(bus.page), 32'h0);
        step_to(145);
        check("page0_again", 32'(bus.led_n), 32'hFE);
        bus.page_next = 1'b1;
        step_to(146);
        bus.page_next = 1'b0;
        check("page_before_reset", 32'(bus.page), 32'h1);
        reset = 1'b0;
        bus.signal_in = '1;
        step_to(147);
        check("midreset_led", 32'(bus.led_n), 32'hFF);
        check("midreset_page", 32'(bus.page), 32'h0);
        check("midreset_tick", 32'(bus.tick), 32'h0);
        reset = 1'b1;
        t = 0;
        step_to(1);
        check("post_reset_direct", 32'(bus.led_n), 32'h00);
`ifdef STATUS_AUTO_PAGE_EN
        step_to(19);
        check("auto_page_hold", 32'(bus.page), 32'h0);
        step_to(20);
        check("auto_page_adv", 32'(bus.page), 32'h1);
        step_to(32);
        bus.page_next = 1'b1;
        step_to(33);
        bus.page_next = 1'b0;
        check("auto_manual_adv", 32'(bus.page), 32'h0);
        step_to(49);
        check("auto_restart_hold", 32'(bus.page), 32'h0);
        step_to(50);
        check("auto_restart_adv", 32'(bus.page), 32'h1);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
